// File: rtl/ni_flit_sender_if.sv
// Descriptor/link bundle between the NI core, ni_flit_sender and the link.
// Field widths and flit-type encodings fall back to local defaults unless noc_parameters.v is already in scope.
`ifndef FTYPEWD
`define FTYPEWD 2
`endif
`ifndef COUNTERFLITWD
`define COUNTERFLITWD 4
`endif
`ifndef ENC_HEAD
`define ENC_HEAD 2'b10
`endif
`ifndef ENC_BODY
`define ENC_BODY 2'b00
`endif
`ifndef ENC_TAIL
`define ENC_TAIL 2'b01
`endif
`ifndef ENC_SING
`define ENC_SING 2'b11
`endif

interface ni_flit_sender_if #(
  parameter int unsigned FLIT_WIDTH = 32
);
  logic                            start;
  logic                            packet_type_is_read;
  logic                            send_payload;
  logic [`COUNTERFLITWD-1:0]       header_flits;
  logic [`COUNTERFLITWD-1:0]       read_payload_flits;
  logic [`COUNTERFLITWD-1:0]       write_payload_flits;
  logic [FLIT_WIDTH-`FTYPEWD-1:0]  data_in;
  logic                            stall;
  logic                            abort;
  logic                            valid;
  logic [FLIT_WIDTH-1:0]           flit;
  logic                            data_ack;
  logic                            sending_header;
  logic [`COUNTERFLITWD-1:0]       flit_count;
  logic                            busy;
  logic                            done;

  modport master (
    output start, packet_type_is_read, send_payload, header_flits,
           read_payload_flits, write_payload_flits, data_in, stall, abort,
    input  valid, flit, data_ack, sending_header, flit_count, busy, done
  );

  modport slave (
    input  start, packet_type_is_read, send_payload, header_flits,
           read_payload_flits, write_payload_flits, data_in, stall, abort,
    output valid, flit, data_ack, sending_header, flit_count, busy, done
  );
endinterface

// File: rtl/ni_flit_sender.sv
// NI transmit serializer: packet descriptor in, typed header/payload flits out.
// Optional early termination via `abort` is compiled in with NI_SENDER_ABORT_EN.
module ni_flit_sender #(
  parameter int unsigned FLIT_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  ni_flit_sender_if.slave lnk
);
  localparam int unsigned CW = `COUNTERFLITWD;
  localparam logic [`FTYPEWD-1:0] T_HEAD = `ENC_HEAD;
  localparam logic [`FTYPEWD-1:0] T_BODY = `ENC_BODY;
  localparam logic [`FTYPEWD-1:0] T_TAIL = `ENC_TAIL;
  localparam logic [`FTYPEWD-1:0] T_SING = `ENC_SING;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   hdr_last_q, hdr_last_d;
  logic [CW-1:0]   rd_last_q, rd_last_d;
  logic [CW-1:0]   wr_last_q, wr_last_d;
  logic            is_read_q, is_read_d;
  logic            send_pay_q, send_pay_d;
  logic            done_q, done_d;

  logic            busy, accept, first_flit, last_flit, force_last, end_flit;
  logic [CW-1:0]   pay_last;
  logic [`FTYPEWD-1:0] ftype;
  logic [FLIT_WIDTH-`FTYPEWD-1:0] body;

`ifdef NI_SENDER_ABORT_EN
  assign force_last = lnk.abort && busy;
`else
  logic abort_unused;
  assign abort_unused = lnk.abort;
  assign force_last   = 1'b0;
`endif

  always_comb begin
    busy       = (state_q != IDLE);
    accept     = busy && !lnk.stall;
    pay_last   = is_read_q ? rd_last_q : wr_last_q;
    first_flit = (state_q == HEADER) && (cnt_q == '0);
    last_flit  = ((state_q == HEADER) && (cnt_q == hdr_last_q) && !send_pay_q) ||
                 ((state_q == PAYLOAD) && (cnt_q == pay_last));
    end_flit   = last_flit || force_last;
    if (first_flit && end_flit) ftype = T_SING;
    else if (first_flit)        ftype = T_HEAD;
    else if (end_flit)          ftype = T_TAIL;
    else                        ftype = T_BODY;
  end

  assign body               = lnk.data_in;
  assign lnk.valid          = busy;
  assign lnk.busy           = busy;
  assign lnk.flit           = {body, ftype};
  assign lnk.data_ack       = accept;
  assign lnk.sending_header = (state_q == HEADER);
  assign lnk.flit_count     = cnt_q;
  assign lnk.done           = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_last_d = hdr_last_q;
    rd_last_d  = rd_last_q;
    wr_last_d  = wr_last_q;
    is_read_d  = is_read_q;
    send_pay_d = send_pay_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lnk.start) begin
          state_d    = HEADER;
          cnt_d      = '0;
          hdr_last_d = lnk.header_flits;
          rd_last_d  = lnk.read_payload_flits;
          wr_last_d  = lnk.write_payload_flits;
          is_read_d  = lnk.packet_type_is_read;
          send_pay_d = lnk.send_payload;
        end
      end
      HEADER: begin
        // end_flit already covers both the header-only packet end and a forced abort
        if (accept) begin
          if (end_flit) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else if (cnt_q == hdr_last_q) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (end_flit) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_last_q <= '0;
      rd_last_q  <= '0;
      wr_last_q  <= '0;
      is_read_q  <= 1'b0;
      send_pay_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_last_q <= hdr_last_d;
      rd_last_q  <= rd_last_d;
      wr_last_q  <= wr_last_d;
      is_read_q  <= is_read_d;
      send_pay_q <= send_pay_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_ni_flit_sender.sv
// Directed bench for ni_flit_sender: flit typing, counters, stall, back-to-back, reset and abort.
`timescale 1ns/1ps
module tb_ni_flit_sender;
  localparam int unsigned DW = 30;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_SING = 2'b11;
  localparam logic [8:0] ST_IDLE = 9'b0_0_0_0_0_0000;
  localparam logic [8:0] ST_DONE = 9'b0_0_0_0_1_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ni_flit_sender_if #(.FLIT_WIDTH(32)) lnk();
  ni_flit_sender #(.FLIT_WIDTH(32)) dut (.clk(clk), .rst(rst), .lnk(lnk));

  always #5 clk = ~clk;

  // {valid, data_ack, sending_header, busy, done, flit_count, flit}
  function automatic logic [40:0] obs();
    return {lnk.valid, lnk.data_ack, lnk.sending_header, lnk.busy, lnk.done,
            lnk.flit_count, lnk.flit};
  endfunction

  function automatic logic [40:0] flit_exp(input logic ack, input logic hdr,
      input logic [3:0] cnt, input logic [DW-1:0] d, input logic [1:0] t);
    return {1'b1, ack, hdr, 1'b1, 1'b0, cnt, d, t};
  endfunction

  task automatic start_pkt(input logic [3:0] h, input logic sp, input logic rd,
                           input logic [3:0] r, input logic [3:0] w);
    @(negedge clk);
    lnk.header_flits = h; lnk.send_payload = sp; lnk.packet_type_is_read = rd;
    lnk.read_payload_flits = r; lnk.write_payload_flits = w; lnk.start = 1'b1;
    @(negedge clk);
    lnk.start = 1'b0;
    lnk.header_flits = 4'hF; lnk.read_payload_flits = 4'hF; lnk.write_payload_flits = 4'hF;
    lnk.send_payload = ~sp; lnk.packet_type_is_read = ~rd;
  endtask

  task automatic test_reset;
    logic [40:0] got;
    #2 rst = 1'b0;
    #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", got[40:32], ST_IDLE);
    end
    @(negedge clk); rst = 1'b1;
    #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", got[40:32], ST_IDLE);
    end
  endtask

  task automatic test_long_packet;
    logic [1:0] et [5];
    logic [3:0] ec [5];
    logic       eh [5];
    logic [40:0] got, exp;
    et = '{T_HEAD, T_BODY, T_BODY, T_BODY, T_TAIL};
    ec = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2};
    eh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    start_pkt(4'd1, 1'b1, 1'b0, 4'd7, 4'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      lnk.data_in = DW'(32'h100 + k);
      #1 got = obs();
      exp = flit_exp(1'b1, eh[k], ec[k], DW'(32'h100 + k), et[k]);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL long_pkt flit%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_DONE) begin
      failures++; $display("FAIL long_pkt done got=%h exp=%h", got[40:32], ST_DONE);
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL long_pkt idle got=%h exp=%h", got[40:32], ST_IDLE);
    end
  endtask

  task automatic test_single;
    logic [40:0] got, exp;
    start_pkt(4'd0, 1'b0, 1'b0, 4'd3, 4'd3);
    lnk.data_in = DW'(32'h2AA);
    #1 got = obs();
    exp = flit_exp(1'b1, 1'b1, 4'd0, DW'(32'h2AA), T_SING);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL single flit got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_DONE) begin
      failures++; $display("FAIL single done got=%h exp=%h", got[40:32], ST_DONE);
    end
  endtask

  task automatic test_read_len;
    logic [40:0] got, exp;
    start_pkt(4'd0, 1'b1, 1'b1, 4'd0, 4'd5);
    lnk.data_in = DW'(32'h300);
    #1 got = obs();
    exp = flit_exp(1'b1, 1'b1, 4'd0, DW'(32'h300), T_HEAD);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL read_len head got=%h exp=%h", got, exp);
    end
    @(negedge clk); lnk.data_in = DW'(32'h301);
    #1 got = obs();
    exp = flit_exp(1'b1, 1'b0, 4'd0, DW'(32'h301), T_TAIL);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL read_len tail got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_DONE) begin
      failures++; $display("FAIL read_len done got=%h exp=%h", got[40:32], ST_DONE);
    end
  endtask

  task automatic test_stall;
    int          idx [7];
    logic        st  [7];
    logic [1:0]  et [4];
    logic [3:0]  ec [4];
    logic        eh [4];
    logic [40:0] got, exp;
    idx = '{0, 1, 1, 1, 1, 2, 3};
    st  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    et  = '{T_HEAD, T_BODY, T_BODY, T_TAIL};
    ec  = '{4'd0, 4'd1, 4'd0, 4'd1};
    eh  = '{1'b1, 1'b1, 1'b0, 1'b0};
    start_pkt(4'd1, 1'b1, 1'b0, 4'd9, 4'd1);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      lnk.stall   = st[c];
      lnk.data_in = DW'(32'h400 + idx[c]);
      #1 got = obs();
      exp = flit_exp(~st[c], eh[idx[c]], ec[idx[c]], DW'(32'h400 + idx[c]), et[idx[c]]);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL stall cycle%0d got=%h exp=%h", c, got, exp);
      end
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_DONE) begin
      failures++; $display("FAIL stall done got=%h exp=%h", got[40:32], ST_DONE);
    end
  endtask

  task automatic test_back_to_back;
    logic        isf [6];
    logic [1:0]  et  [6];
    logic [3:0]  ec  [6];
    logic [40:0] got, exp;
    isf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    et  = '{T_HEAD, T_TAIL, T_BODY, T_HEAD, T_TAIL, T_BODY};
    ec  = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0};
    @(negedge clk);
    lnk.header_flits = 4'd1; lnk.send_payload = 1'b0; lnk.packet_type_is_read = 1'b0;
    lnk.read_payload_flits = 4'd2; lnk.write_payload_flits = 4'd2; lnk.start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      lnk.data_in = DW'(32'h500 + c);
      #1 got = obs();
      if (isf[c]) begin
        exp = flit_exp(1'b1, 1'b1, ec[c], DW'(32'h500 + c), et[c]);
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL b2b cycle%0d got=%h exp=%h", c, got, exp);
        end
      end else begin
        checks++;
        if (got[40:32] !== ST_DONE) begin
          failures++; $display("FAIL b2b done cycle%0d got=%h exp=%h", c, got[40:32], ST_DONE);
        end
      end
      if (c == 3) lnk.start = 1'b0;
    end
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL b2b idle got=%h exp=%h", got[40:32], ST_IDLE);
    end
  endtask

  task automatic test_reset_midpacket;
    logic [40:0] got, exp;
    start_pkt(4'd1, 1'b1, 1'b0, 4'd0, 4'd2);
    lnk.data_in = DW'(32'h600);
    #1 got = obs();
    exp = flit_exp(1'b1, 1'b1, 4'd0, DW'(32'h600), T_HEAD);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL rst_mid head got=%h exp=%h", got, exp);
    end
    @(negedge clk); #1 rst = 1'b0;
    #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL rst_mid drop got=%h exp=%h", got[40:32], ST_IDLE);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_IDLE) begin
      failures++; $display("FAIL rst_mid after got=%h exp=%h", got[40:32], ST_IDLE);
    end
  endtask

  task automatic test_abort;
    logic [1:0]  et [6];
    logic [3:0]  ec [6];
    logic        eh [6];
    logic [40:0] got, exp;
    et = '{T_HEAD, T_BODY, T_BODY, T_BODY, T_BODY, T_TAIL};
    ec = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3};
    eh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    start_pkt(4'd1, 1'b1, 1'b0, 4'd0, 4'd3);
    lnk.data_in = DW'(32'h700);
    #1 got = obs();
    exp = flit_exp(1'b1, 1'b1, 4'd0, DW'(32'h700), T_HEAD);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL abort head got=%h exp=%h", got, exp);
    end
    // second flit: one stalled cycle with abort, then accepted with abort
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      lnk.abort = 1'b1; lnk.stall = (c == 0); lnk.data_in = DW'(32'h701);
      #1 got = obs();
`ifdef NI_SENDER_ABORT_EN
      exp = flit_exp(c != 0, 1'b1, 4'd1, DW'(32'h701), T_TAIL);
`else
      exp = flit_exp(c != 0, 1'b1, 4'd1, DW'(32'h701), T_BODY);
`endif
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL abort flit1 cycle%0d got=%h exp=%h", c, got, exp);
      end
    end
    lnk.abort = 1'b0;
`ifndef NI_SENDER_ABORT_EN
    for (int k = 2; k < 6; k++) begin
      @(negedge clk);
      lnk.data_in = DW'(32'h700 + k);
      #1 got = obs();
      exp = flit_exp(1'b1, eh[k], ec[k], DW'(32'h700 + k), et[k]);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL abort_off flit%0d got=%h exp=%h", k, got, exp);
      end
    end
`endif
    @(negedge clk); #1 got = obs();
    checks++;
    if (got[40:32] !== ST_DONE) begin
      failures++; $display("FAIL abort done got=%h exp=%h", got[40:32], ST_DONE);
    end
  endtask

  initial begin
    lnk.start = 1'b0; lnk.packet_type_is_read = 1'b0; lnk.send_payload = 1'b0;
    lnk.header_flits = '0; lnk.read_payload_flits = '0; lnk.write_payload_flits = '0;
    lnk.data_in = '0; lnk.stall = 1'b0; lnk.abort = 1'b0;
    test_reset;
    test_long_packet;
    test_single;
    test_read_len;
    test_stall;
    test_back_to_back;
    test_reset_midpacket;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
